// File: rtl/pc_tx.sv
// pc_tx: word FIFO feeding a UART 8N1 serialiser toward the FTDI USB bridge.
// Each 32-bit word goes out as four bytes, byte0 = word[7:0] first.
// Handshake: i_write_word_cmd is a one-cycle push strobe with no ready path.
// A push is accepted only when o_fifo_is_full_sig is low at that clock edge.
// A rejected push is reported by o_word_dropped in the following cycle.
module pc_tx #(
    parameter int CLKS_PER_BIT = 435,
    parameter int FIFO_ADDR_W  = 3
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_write_word_cmd,
    input  logic [31:0]          i_tx_word,
    output logic                 o_fifo_is_full_sig,
    output logic                 o_fifo_is_empty_sig,
    output logic [FIFO_ADDR_W:0] o_fifo_level,
    output logic                 o_word_dropped,
    output logic                 o_tx_serial,
    output logic                 o_tx_active,
    output logic                 o_word_sent,
    output logic [2:0]           o_dbg_state
);
    localparam int                   DEPTH      = 2**FIFO_ADDR_W;
    localparam logic [FIFO_ADDR_W:0] C_DEPTH    = {1'b1, {FIFO_ADDR_W{1'b0}}};
    localparam logic [15:0]          C_BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // ---------------- word FIFO ----------------
    logic [31:0]            r_mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] r_wr_ptr;
    logic [FIFO_ADDR_W-1:0] r_rd_ptr;
    logic [FIFO_ADDR_W:0]   r_level;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_dropped;
    logic                   w_wr_en;
    logic                   w_pop;
    logic [FIFO_ADDR_W:0]   w_level_nxt;
    logic [31:0]            w_rd_data;

    // The full flag seen at the edge decides, even if a pop frees a slot on the same edge.
    assign w_wr_en   = i_write_word_cmd & ~r_full;
    assign w_rd_data = r_mem[r_rd_ptr];

    // Next word count from the accepted write and the pop.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_en, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage array: no reset needed, the level and pointers say what is valid.
    always_ff @(posedge i_clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_tx_word;
        end
    end

    // Pointers, level and registered flags.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_dropped <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level   <= w_level_nxt;
            r_full    <= (w_level_nxt == C_DEPTH);
            r_empty   <= (w_level_nxt == '0);
            r_dropped <= i_write_word_cmd & r_full;
        end
    end

    // ---------------- serialiser FSM ----------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_baud;
    logic [15:0] w_baud_nxt;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_nxt;
    logic [1:0]  r_byte_idx;
    logic [1:0]  w_byte_nxt;
    logic [31:0] r_shift;
    logic [31:0] w_shift_nxt;
    logic        r_tx_serial;
    logic        w_serial_nxt;
    logic        r_word_sent;
    logic        w_sent_nxt;
    logic        w_baud_done;

    assign w_baud_done = (r_baud == C_BAUD_MAX);

    // State and datapath registers; the serial line is always a flop output.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_shift     <= '0;
            r_tx_serial <= 1'b1;
            r_word_sent <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_baud      <= w_baud_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_byte_idx  <= w_byte_nxt;
            r_shift     <= w_shift_nxt;
            r_tx_serial <= w_serial_nxt;
            r_word_sent <= w_sent_nxt;
        end
    end

    // Next state and next datapath values. The shift register is consumed
    // LSB first, so after eight data bits the next byte sits in bits [7:0].
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit_idx;
        w_byte_nxt   = r_byte_idx;
        w_shift_nxt  = r_shift;
        w_serial_nxt = r_tx_serial;
        w_sent_nxt   = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_serial_nxt = 1'b1;
                if (!r_empty) begin
                    // The popped word is captured here so LOAD can start the frame.
                    w_pop       = 1'b1;
                    w_shift_nxt = w_rd_data;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_byte_nxt   = 2'd0;
                w_bit_nxt    = 3'd0;
                w_baud_nxt   = '0;
                w_serial_nxt = 1'b0;
                w_state_nxt  = S_START;
            end
            S_START: begin
                if (w_baud_done) begin
                    w_baud_nxt   = '0;
                    w_bit_nxt    = 3'd0;
                    w_serial_nxt = r_shift[0];
                    w_shift_nxt  = {1'b0, r_shift[31:1]};
                    w_state_nxt  = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_serial_nxt = 1'b1;
                        w_state_nxt  = S_STOP;
                    end else begin
                        w_bit_nxt    = r_bit_idx + 3'd1;
                        w_serial_nxt = r_shift[0];
                        w_shift_nxt  = {1'b0, r_shift[31:1]};
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_nxt = '0;
                    if (r_byte_idx != 2'd3) begin
                        // Next byte of the same word follows with no idle gap.
                        w_byte_nxt   = r_byte_idx + 2'd1;
                        w_serial_nxt = 1'b0;
                        w_state_nxt  = S_START;
                    end else begin
                        w_sent_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: begin
                w_serial_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    assign o_fifo_is_full_sig  = r_full;
    assign o_fifo_is_empty_sig = r_empty;
    assign o_fifo_level        = r_level;
    assign o_word_dropped      = r_dropped;
    assign o_tx_serial         = r_tx_serial;
    assign o_tx_active         = (r_state != S_IDLE);
    assign o_word_sent         = r_word_sent;
    assign o_dbg_state         = r_state;
endmodule

// File: tb/tb_pc_tx.sv
// Testbench for pc_tx with CLKS_PER_BIT=4 and an 8-word FIFO.
module tb_pc_tx;
    localparam int CPB = 4;
    localparam int AW  = 3;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        i_write = 1'b0;
    logic [31:0] i_word  = '0;
    logic        full;
    logic        empty;
    logic        dropped;
    logic        serial;
    logic        active;
    logic        sent;
    logic [AW:0] level;
    logic [2:0]  dbg_state;

    int n_vec     = 0;
    int n_err     = 0;
    int cyc       = 0;
    int n_sent    = 0;
    int exp_sent  = 0;
    int n_frames  = 0;
    int last_wr   = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         sent_q[$];

    typedef struct {
        logic        wr;
        logic [31:0] word;
        logic        acc;
        logic [AW:0] e_lvl;
        logic        e_full;
        logic        e_empty;
        logic        e_drop;
    } vec_t;

    vec_t vt[11];

    pc_tx #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_W(AW)) dut (
        .i_clock            (clk),
        .i_reset_n          (rst_n),
        .i_write_word_cmd   (i_write),
        .i_tx_word          (i_word),
        .o_fifo_is_full_sig (full),
        .o_fifo_is_empty_sig(empty),
        .o_fifo_level       (level),
        .o_word_dropped     (dropped),
        .o_tx_serial        (serial),
        .o_tx_active        (active),
        .o_word_sent        (sent),
        .o_dbg_state        (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int k);
        if (q.size() > k) return q[k];
        return -1;
    endfunction

    task automatic push_exp(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    // One-cycle push; expect_tx says whether the bench expects the word on the line.
    task automatic push(input logic [31:0] w, input logic expect_tx);
        i_write = 1'b1;
        i_word  = w;
        @(posedge clk);
        #1;
        last_wr = cyc;
        i_write = 1'b0;
        if (expect_tx) begin
            push_exp(w);
            exp_sent++;
        end
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(exp_q.size() == 0 && empty === 1'b1 && active === 1'b0) && t < 4000);
        n_vec++;
        if (t >= 4000) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d bytes pending, expected 0", name, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Serial decoder: every one of the CPB samples of each bit must agree.
    logic       dec_active = 1'b0;
    int         dec_cnt    = 0;
    logic [7:0] dec_byte   = '0;
    logic       dec_ok     = 1'b1;
    logic [7:0] dec_exp;
    int         bit_i;
    int         sub_i;
    always @(negedge clk) begin
        if (!rst_n) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (serial === 1'b0) begin
                dec_active = 1'b1;
                dec_cnt    = 1;
                dec_ok     = 1'b1;
                dec_byte   = '0;
                n_frames++;
                start_q.push_back(cyc);
            end
        end else begin
            bit_i = dec_cnt / CPB;
            sub_i = dec_cnt % CPB;
            if (bit_i == 0) begin
                if (serial !== 1'b0) dec_ok = 1'b0;
            end else if (bit_i <= 8) begin
                if (sub_i == 0) dec_byte[bit_i-1] = serial;
                else if (serial !== dec_byte[bit_i-1]) dec_ok = 1'b0;
            end else if (serial !== 1'b1) begin
                dec_ok = 1'b0;
            end
            if (dec_cnt == 10*CPB - 1) begin
                dec_active = 1'b0;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rx_byte: got %02h, expected no frame", dec_byte);
                end else begin
                    dec_exp = exp_q.pop_front();
                    if (!dec_ok || dec_byte !== dec_exp) begin
                        n_err++;
                        $display("FAIL rx_byte: got %02h framing_ok=%0d expected %02h framing_ok=1",
                                 dec_byte, dec_ok, dec_exp);
                    end
                end
            end else begin
                dec_cnt++;
            end
        end
    end

    // Word-sent pulse monitor
    always @(negedge clk) begin
        if (rst_n && sent === 1'b1) begin
            n_sent++;
            sent_q.push_back(cyc);
        end
    end

    initial begin : main
        int c0;
        int t;
        logic [31:0] w;

        vt[0]  = '{1'b0, 32'h00000000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 32'h76543210, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 32'h89ABCDEF, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 32'h0F0F0F0F, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 32'hF0F0F0F0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 32'h13579BDF, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 32'h2468ACE0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 32'h80000001, 1'b1, 4'd7, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 32'h7FFFFFFE, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 32'hDEADBEEF, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};
        vt[10] = '{1'b0, 32'h00000000, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_serial", 32'(serial), 32'd1);
        check("rst_flags", 32'({level, full, empty, dropped, active, sent}), 32'({4'd0, 5'b01000}));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_flags", 32'({level, full, empty, dropped, active, sent, serial}),
              32'({4'd0, 6'b010001}));

        // Single word: start bit 2 clocks after the write edge, sent 160 clocks later
        start_q.delete();
        sent_q.delete();
        push(32'hA55A3C01, 1'b1);
        c0 = last_wr;
        wait_idle("single");
        check("single_frames", 32'(start_q.size()), 32'd4);
        check("single_start", 32'(qget(start_q, 0)), 32'(c0 + 2));
        check("single_sent_cnt", 32'(sent_q.size()), 32'd1);
        check("single_sent_at", 32'(qget(sent_q, 0)), 32'(c0 + 2 + 40*CPB));

        // Fill while the line is busy with a prior word
        push(32'h0BADF00D, 1'b1);
        repeat (3) @(negedge clk);
        foreach (vt[i]) begin
            i_write = vt[i].wr;
            i_word  = vt[i].word;
            @(posedge clk);
            #1;
            i_write = 1'b0;
            if (vt[i].acc) begin
                push_exp(vt[i].word);
                exp_sent++;
            end
            @(negedge clk);
            check($sformatf("fill%0d_lvl_full_empty_drop", i),
                  32'({level, full, empty, dropped}),
                  32'({vt[i].e_lvl, vt[i].e_full, vt[i].e_empty, vt[i].e_drop}));
        end

        // Write on the same edge the FSM pops from a full FIFO
        t = 0;
        while (sent !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("full_pop_wait", 32'(t < 400), 32'd1);
        i_write = 1'b1;
        i_word  = 32'hBAD0BAD0;
        @(posedge clk);
        #1;
        i_write = 1'b0;
        @(negedge clk);
        check("full_pop_lvl_full_empty_drop", 32'({level, full, empty, dropped}), 32'({4'd7, 3'b001}));
        wait_idle("fill");
        check("fill_sent", 32'(n_sent), 32'(exp_sent));

        // Back-to-back words: 2 idle clocks between words, none between bytes
        start_q.delete();
        sent_q.delete();
        push(32'h00000000, 1'b1);
        c0 = last_wr;
        push(32'hFFFFFFFF, 1'b1);
        push(32'h12345678, 1'b1);
        wait_idle("b2b");
        check("b2b_frames", 32'(start_q.size()), 32'd12);
        check("b2b_first_start", 32'(qget(start_q, 0)), 32'(c0 + 2));
        for (int k = 1; k < 12; k++) begin
            check($sformatf("b2b_gap%0d", k), 32'(qget(start_q, k) - qget(start_q, k-1)),
                  32'((k % 4 == 0) ? 10*CPB + 2 : 10*CPB));
        end
        check("b2b_sent_cnt", 32'(sent_q.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_sent%0d_at", k), 32'(qget(sent_q, k)), 32'(qget(start_q, 4*k) + 40*CPB));
        end

        // Reset during data bit d3 of byte 1, with a second word still queued
        start_q.delete();
        push(32'h11223344, 1'b0);
        c0 = last_wr;
        exp_q.push_back(8'h44);
        push(32'h55667788, 1'b0);
        while (cyc < c0 + 2 + 10*CPB + 4*CPB + 2) @(negedge clk);
        check("midrst_pre_state", 32'(dbg_state), 32'd3);
        check("midrst_pre_serial", 32'(serial), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_flags", 32'({level, full, empty, active, serial}), 32'({4'd0, 4'b0101}));
        repeat (2) @(negedge clk);
        check("midrst_byte0_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_idle_after", 32'({serial, active, empty}), 32'({3'b101}));
        check("midrst_frames", 32'(start_q.size()), 32'd2);
        push(32'hCAFEBABE, 1'b1);
        wait_idle("cafe");
        check("cafe_frames", 32'(start_q.size()), 32'd6);
        check("cafe_sent", 32'(n_sent), 32'(exp_sent));

        // Loopback through the decoder: 16 random words in two batches
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) begin
                w = $urandom;
                push(w, 1'b1);
            end
            wait_idle($sformatf("loop%0d", r));
        end
        check("loop_sent", 32'(n_sent), 32'(exp_sent));
        check("loop_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
